// File: rtl/syn_fifo_flags.sv
// syn_fifo_flags: parametrised single-clock FIFO with an occupancy counter,
// so all M entries are usable and M need not be a power of two.
//
// Parameters:
//   N        data width
//   M        depth in entries (>= 2)
//   AF_LEVEL almost_full when count >= AF_LEVEL (1..M)
//   AE_LEVEL almost_empty when count <= AE_LEVEL (0..M-1)
//   FWFT     0 = registered read (1-cycle latency), 1 = first-word-fall-through
//   CW       count width, derived from M
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   data_in, write_en write side
//   read_en           read side
//   clr_err           synchronous clear of the sticky error flags
//   data_out          read data
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow                             sticky rejected-op flags
module syn_fifo_flags #(
  parameter int N        = 8,
  parameter int M        = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  localparam int CW      = $clog2(M + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  data_in,
  input  logic          write_en,
  input  logic          read_en,
  input  logic          clr_err,
  output logic [N-1:0]  data_out,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = $clog2(M);

  // Reject illegal configurations at elaboration.
  generate
    if (M < 2 || AF_LEVEL < 1 || AF_LEVEL > M || AE_LEVEL < 0 || AE_LEVEL > M - 1 ||
        FWFT < 0 || FWFT > 1) begin : g_bad_param
      $error("syn_fifo_flags: illegal parameter combination");
    end
  endgenerate

  logic [N-1:0]  mem_r [M];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          full_r;
  logic          empty_r;
  logic          af_r;
  logic          ae_r;
  logic          ovf_r;
  logic          udf_r;
  logic [N-1:0]  dout_r;
  logic          rd_ok_s;
  logic          wr_ok_s;

  // Pointer increment with explicit wrap so non-power-of-two depths work
  // without an extra wrap bit.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(M - 1)) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Accept logic and next occupancy. A full FIFO still takes a write when a
  // read is accepted in the same cycle, since a slot frees at that edge.
  always_comb begin
    rd_ok_s      = read_en && !empty_r;
    wr_ok_s      = write_en && (!full_r || rd_ok_s);
    count_next_s = count_r + CW'(wr_ok_s) - CW'(rd_ok_s);
  end

  // Pointers, count, registered flags, sticky errors and read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
      dout_r   <= {N{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
        // Registered-read data in standard mode; last popped word in FWFT.
        dout_r   <= mem_r[rd_ptr_r];
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(M));
      empty_r <= (count_next_s == {CW{1'b0}});
      af_r    <= (count_next_s >= CW'(AF_LEVEL));
      ae_r    <= (count_next_s <= CW'(AE_LEVEL));
      // Set wins over clear when both happen in one cycle.
      ovf_r   <= (write_en && !wr_ok_s) || (ovf_r && !clr_err);
      udf_r   <= (read_en && !rd_ok_s) || (udf_r && !clr_err);
    end
  end

  // Storage array; not cleared by reset, but reset blocks a write that cycle.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !reset) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Output data: in FWFT mode the head word is visible while not empty,
  // otherwise the register holds the last word read.
  always_comb begin
    if (FWFT == 1 && !empty_r) begin
      data_out = mem_r[rd_ptr_r];
    end else begin
      data_out = dout_r;
    end
  end

  // Status outputs are straight from registers.
  always_comb begin
    full         = full_r;
    empty        = empty_r;
    almost_full  = af_r;
    almost_empty = ae_r;
    count        = count_r;
    overflow     = ovf_r;
    underflow    = udf_r;
  end

endmodule
